conv_loop_gen: RTL

Parametrised loop-nest generator for the convolution datapath. It walks output channel, output row, output column, kernel row, kernel column and input channel. For every multiply-accumulate beat it emits the coordinate tuple, the padded input address, a bounds flag and accumulator control flags. It sits between the layer controller (start/done) and the MAC/accumulator stage (valid/ready). Compared with the previous iterator it adds:

- separate height and width
- derived output size
- start/done and backpressure handshakes
- a depthwise mode
- explicit first/last flags in place of combinational save detection

---
 rtl/conv_loop_gen.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/conv_loop_gen.sv
// conv_loop_gen: walks the convolution loop nest (oc, oy, ox, ky, kx, ic)
// and emits one multiply-accumulate beat per accepted valid/ready handshake,
// together with the padded input address, a bounds flag and the
// first/last accumulator controls.
module conv_loop_gen #(
  parameter int IMG_H     = 32,
  parameter int IMG_W     = 32,
  parameter int IN_CH     = 3,
  parameter int OUT_CH    = 32,
  parameter int K_H       = 5,
  parameter int K_W       = 5,
  parameter int STRIDE    = 1,
  parameter int PADDING   = 2,
  parameter int DEPTHWISE = 0,
  parameter int CW        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 ready,
  output logic                 busy,
  output logic                 valid,
  output logic [CW-1:0]        oc,
  output logic [CW-1:0]        oy,
  output logic [CW-1:0]        ox,
  output logic [CW-1:0]        ky,
  output logic [CW-1:0]        kx,
  output logic [CW-1:0]        ic,
  output logic signed [CW:0]   in_row,
  output logic signed [CW:0]   in_col,
  output logic                 in_bounds,
  output logic                 first,
  output logic                 last,
  output logic                 done
);

  localparam int OUT_H   = (IMG_H + 2 * PADDING - K_H) / STRIDE + 1;
  localparam int OUT_W   = (IMG_W + 2 * PADDING - K_W) / STRIDE + 1;
  // Depthwise mode collapses the input-channel loop to a single iteration.
  localparam int IC_LAST = (DEPTHWISE != 0) ? 0 : IN_CH - 1;

  localparam logic [CW-1:0] OC_MAX = CW'(OUT_CH - 1);
  localparam logic [CW-1:0] OY_MAX = CW'(OUT_H - 1);
  localparam logic [CW-1:0] OX_MAX = CW'(OUT_W - 1);
  localparam logic [CW-1:0] KY_MAX = CW'(K_H - 1);
  localparam logic [CW-1:0] KX_MAX = CW'(K_W - 1);
  localparam logic [CW-1:0] IC_MAX = CW'(IC_LAST);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] oc_q, oc_d, oy_q, oy_d, ox_q, ox_d;
  logic [CW-1:0] ky_q, ky_d, kx_q, kx_d, ic_q, ic_d;
  logic          valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  logic oc_wrap, oy_wrap, ox_wrap, ky_wrap, kx_wrap, ic_wrap;

  assign oc_wrap = (oc_q == OC_MAX);
  assign oy_wrap = (oy_q == OY_MAX);
  assign ox_wrap = (ox_q == OX_MAX);
  assign ky_wrap = (ky_q == KY_MAX);
  assign kx_wrap = (kx_q == KX_MAX);
  assign ic_wrap = (ic_q == IC_MAX);

  // Next-state logic: start a pass from IDLE, step the odometer on each accepted beat.
  always_comb begin
    state_d = state_q;
    oc_d    = oc_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    ic_d    = ic_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          oc_d    = '0;
          oy_d    = '0;
          ox_d    = '0;
          ky_d    = '0;
          kx_d    = '0;
          ic_d    = '0;
        end
      end
      RUN: begin
        if (valid_q && ready) begin
          if (ic_wrap && kx_wrap && ky_wrap && ox_wrap && oy_wrap && oc_wrap) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            oc_d    = '0;
            oy_d    = '0;
            ox_d    = '0;
            ky_d    = '0;
            kx_d    = '0;
            ic_d    = '0;
          end else begin
            ic_d = ic_wrap ? '0 : ic_q + 1'b1;
            if (ic_wrap) begin
              kx_d = kx_wrap ? '0 : kx_q + 1'b1;
              if (kx_wrap) begin
                ky_d = ky_wrap ? '0 : ky_q + 1'b1;
                if (ky_wrap) begin
                  ox_d = ox_wrap ? '0 : ox_q + 1'b1;
                  if (ox_wrap) begin
                    oy_d = oy_wrap ? '0 : oy_q + 1'b1;
                    if (oy_wrap) begin
                      oc_d = oc_q + 1'b1;
                    end
                  end
                end
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and coordinate registers; reset abandons any pass without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      oc_q    <= '0;
      oy_q    <= '0;
      ox_q    <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      ic_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      oc_q    <= oc_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
      ic_q    <= ic_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign oc    = oc_q;
  assign oy    = oy_q;
  assign ox    = ox_q;
  assign ky    = ky_q;
  assign kx    = kx_q;
  // In depthwise mode each output channel reads its own input channel.
  assign ic    = (DEPTHWISE != 0) ? oc_q : ic_q;

  // Padded input address is formed at one extra signed bit so negative rows survive.
  assign in_row = $signed({1'b0, oy_q}) * $signed((CW+1)'(STRIDE))
                + $signed({1'b0, ky_q}) - $signed((CW+1)'(PADDING));
  assign in_col = $signed({1'b0, ox_q}) * $signed((CW+1)'(STRIDE))
                + $signed({1'b0, kx_q}) - $signed((CW+1)'(PADDING));

  assign in_bounds = !in_row[CW] && (in_row < $signed((CW+1)'(IMG_H)))
                  && !in_col[CW] && (in_col < $signed((CW+1)'(IMG_W)));

  assign first = (ky_q == '0) && (kx_q == '0) && (ic_q == '0);
  assign last  = ky_wrap && kx_wrap && ic_wrap;

endmodule
